tnet_cmd_dec: RTL and testbench
===============================

TNET_CMD_DEC -- requirements
Module: tnet_cmd_dec

Interface
REQ-001 SHALL have parameter BCAST_ID, default 10'h3FF, broadcast destination address.
REQ-002 SHALL have c_clk_i  input  1  command clock; one clock, all logic on its rising edge.
REQ-003 SHALL have c_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have param_NN  input  10  node count; param_ID  input  10  own node ID.
REQ-005 SHALL have rx_vld_i  input  1, rx_header_i  input  64, rx_data_i  input  64: received packet from link.
REQ-006 SHALL have rx_rdy_o  output  1  decoder can accept a packet.
REQ-007 SHALL have loc_req_o  output  1, loc_ack_i  input  1, loc_op_o  output  5, loc_ret_o  output  1, loc_src_o  output  10, loc_hdt_o  output  24, loc_data_o  output  32x2: local delivery.
REQ-008 SHALL have fwd_req_o  output  1, fwd_ack_i  input  1, fwd_header_o  output  64, fwd_data_o  output  64: forward to next node.
REQ-009 SHALL have err_o  output  1 (one-cycle drop pulse) and cnt_do  output  32 (statistics).

Function
REQ-010 SHALL parse header as [63:62] type, [61:57] op, [56:54] SWA, [53:44] DEST, [43:34] SOURCE, [33:24] STEP, [23:0] HDT.
REQ-011 SHALL use FSM IDLE, DECODE, DISPATCH; rx_rdy_o=1 only in IDLE.
REQ-012 SHALL capture header/data when rx_vld_i & rx_rdy_o, IDLE->DECODE.
REQ-013 DECODE (one cycle) SHALL classify: DROP if type!=0, op==0, or STEP>=param_NN; RET if SOURCE==param_ID; else LOC if DEST==param_ID or DEST==BCAST_ID; FWD if DEST!=param_ID and not RET.
REQ-014 DROP SHALL pulse err_o one cycle in DECODE and return to IDLE; no requests issued.
REQ-015 On entering DISPATCH SHALL assert loc_req_o if LOC or RET, fwd_req_o if FWD; both may be high together (broadcast).
REQ-016 loc_ret_o SHALL equal 1 for RET class, 0 otherwise; loc_op_o=op, loc_src_o=SOURCE, loc_hdt_o=HDT, loc_data_o[0]=data[31:0], loc_data_o[1]=data[63:32].
REQ-017 fwd_header_o SHALL equal captured header with STEP replaced by STEP+1 (10-bit); fwd_data_o unmodified.
REQ-018 Each req SHALL stay high until its ack is sampled high, then drop next cycle; ack while req low ignored.
REQ-019 DISPATCH->IDLE SHALL occur the cycle after the last outstanding req is acked; simultaneous loc_ack_i and fwd_ack_i clear both same cycle.
REQ-020 All outputs SHALL be registered; latency rx handshake to req high = 2 cycles.
REQ-021 Outputs SHALL hold stable while req high.

Reset
REQ-022 Reset SHALL force IDLE, rx_rdy_o=0 during reset and 1 first cycle after release, all req/err outputs 0, data/header registers 0, counters 0.
REQ-023 Reset mid-DISPATCH SHALL abandon the packet; no req reasserted afterwards.

Configuration
REQ-024 Macro TNET_DEC_STAT_EN defined: cnt_do = {rx_cnt[7:0], loc_cnt[7:0], fwd_cnt[7:0], drop_cnt[7:0]}, each incremented once per event, wrapping 255->0.
REQ-025 Macro TNET_DEC_STAT_EN undefined: cnt_do tied 0, no counter logic.

Verification
REQ-026 ID=3, NN=8, header DEST=3 SOURCE=1 STEP=2 op=5 -> loc_req_o at cycle 2, loc_op_o=5, loc_src_o=1, no fwd_req_o.
REQ-027 ID=3, DEST=6 STEP=2 -> fwd_req_o only, fwd_header_o STEP=3, other fields equal input.
REQ-028 ID=3, DEST=10'h3FF SOURCE=0 -> loc_req_o and fwd_req_o together; ack fwd at cycle 3, loc at cycle 6 -> rx_rdy_o returns cycle 7.
REQ-029 ID=3, SOURCE=3 DEST=10'h3FF -> loc_req_o with loc_ret_o=1, no forward; STEP=8 with NN=8 -> err_o pulse, drop_cnt=1.
REQ-030 Assert c_rst_i while loc_req_o high -> loc_req_o 0 asynchronously, IDLE after release, cnt_do=0.

Source files
------------

// File: rtl/tnet_cmd_dec.sv
// Command decoder: classifies packets from the link and hands them to the local port, the next node, or both.
// Optional statistics counters are built when TNET_DEC_STAT_EN is defined; otherwise cnt_do is tied to zero.
module tnet_cmd_dec #(
  parameter logic [9:0] BCAST_ID = 10'h3FF
) (
  input  logic             c_clk_i,
  input  logic             c_rst_i,
  input  logic [9:0]       param_NN,
  input  logic [9:0]       param_ID,
  input  logic             rx_vld_i,
  input  logic [63:0]      rx_header_i,
  input  logic [63:0]      rx_data_i,
  output logic             rx_rdy_o,
  output logic             loc_req_o,
  input  logic             loc_ack_i,
  output logic [4:0]       loc_op_o,
  output logic             loc_ret_o,
  output logic [9:0]       loc_src_o,
  output logic [23:0]      loc_hdt_o,
  output logic [1:0][31:0] loc_data_o,
  output logic             fwd_req_o,
  input  logic             fwd_ack_i,
  output logic [63:0]      fwd_header_o,
  output logic [63:0]      fwd_data_o,
  output logic             err_o,
  output logic [31:0]      cnt_do
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_DISPATCH} state_t;

  state_t      state;
  logic        cls_drop, cls_loc, cls_fwd;
  logic        take;
  logic [1:0]  h_typ;
  logic [4:0]  h_op;
  logic [9:0]  h_dest, h_src, h_step;
  logic        c_drop, c_ret, c_loc, c_fwd;
  logic        loc_pend, fwd_pend;

  assign h_typ  = rx_header_i[63:62];
  assign h_op   = rx_header_i[61:57];
  assign h_dest = rx_header_i[53:44];
  assign h_src  = rx_header_i[43:34];
  assign h_step = rx_header_i[33:24];

  assign take = (state == S_IDLE) && rx_vld_i && rx_rdy_o;

  // Classification is resolved at capture so err_o can be a registered pulse during DECODE.
  always_comb begin
    c_drop   = (h_typ != 2'd0) || (h_op == 5'd0) || (h_step >= param_NN);
    c_ret    = (h_src == param_ID);
    c_loc    = c_ret || (h_dest == param_ID) || (h_dest == BCAST_ID);
    c_fwd    = !c_ret && (h_dest != param_ID);
    loc_pend = loc_req_o && !loc_ack_i;
    fwd_pend = fwd_req_o && !fwd_ack_i;
  end

  // NOTE: state and output registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge c_clk_i or posedge c_rst_i) begin
    if (c_rst_i) begin
      state        <= S_IDLE;
      rx_rdy_o     <= 1'b0;
      loc_req_o    <= 1'b0;
      fwd_req_o    <= 1'b0;
      err_o        <= 1'b0;
      cls_drop     <= 1'b0;
      cls_loc      <= 1'b0;
      cls_fwd      <= 1'b0;
      loc_op_o     <= '0;
      loc_ret_o    <= 1'b0;
      loc_src_o    <= '0;
      loc_hdt_o    <= '0;
      loc_data_o   <= '0;
      fwd_header_o <= '0;
      fwd_data_o   <= '0;
    end else begin
      err_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (take) begin
            state        <= S_DECODE;
            rx_rdy_o     <= 1'b0;
            err_o        <= c_drop;
            cls_drop     <= c_drop;
            cls_loc      <= c_loc && !c_drop;
            cls_fwd      <= c_fwd && !c_drop;
            loc_op_o     <= h_op;
            loc_ret_o    <= c_ret && !c_drop;
            loc_src_o    <= h_src;
            loc_hdt_o    <= rx_header_i[23:0];
            loc_data_o   <= rx_data_i;
            fwd_header_o <= {rx_header_i[63:34], h_step + 10'd1, rx_header_i[23:0]};
            fwd_data_o   <= rx_data_i;
          end else begin
            rx_rdy_o <= 1'b1;
          end
        end
        S_DECODE: begin
          if (cls_drop) begin
            state    <= S_IDLE;
            rx_rdy_o <= 1'b1;
          end else begin
            loc_req_o <= cls_loc;
            fwd_req_o <= cls_fwd;
            state     <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          loc_req_o <= loc_pend;
          fwd_req_o <= fwd_pend;
          if (!loc_pend && !fwd_pend) begin
            state    <= S_IDLE;
            rx_rdy_o <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TNET_DEC_STAT_EN
  logic [7:0] rx_cnt, loc_cnt, fwd_cnt, drop_cnt;

  // Counters wrap naturally at 8 bits.
  always_ff @(posedge c_clk_i or posedge c_rst_i) begin
    if (c_rst_i) begin
      rx_cnt   <= '0;
      loc_cnt  <= '0;
      fwd_cnt  <= '0;
      drop_cnt <= '0;
    end else if (take) begin
      rx_cnt   <= rx_cnt + 8'd1;
      loc_cnt  <= loc_cnt + {7'd0, c_loc && !c_drop};
      fwd_cnt  <= fwd_cnt + {7'd0, c_fwd && !c_drop};
      drop_cnt <= drop_cnt + {7'd0, c_drop};
    end
  end

  assign cnt_do = {rx_cnt, loc_cnt, fwd_cnt, drop_cnt};
`else
  assign cnt_do = 32'd0;
`endif

endmodule

// File: tb/tb_tnet_cmd_dec.sv
// Scoreboard bench for tnet_cmd_dec: randomized packets vs. a rule-level reference model, plus directed timing cases.
module tb_tnet_cmd_dec;
  localparam logic [9:0] BCAST = 10'h3FF;

  typedef struct {
    logic        drop, ret, loc, fwd;
    logic [4:0]  op;
    logic [9:0]  src;
    logic [23:0] hdt;
    logic [63:0] data, fhdr;
    int          hs;
  } exp_t;

  logic             c_clk_i = 1'b0;
  logic             c_rst_i;
  logic [9:0]       param_NN, param_ID;
  logic             rx_vld_i;
  logic [63:0]      rx_header_i, rx_data_i;
  logic             rx_rdy_o, loc_req_o, loc_ack_i, loc_ret_o;
  logic [4:0]       loc_op_o;
  logic [9:0]       loc_src_o;
  logic [23:0]      loc_hdt_o;
  logic [1:0][31:0] loc_data_o;
  logic             fwd_req_o, fwd_ack_i, err_o;
  logic [63:0]      fwd_header_o, fwd_data_o;
  logic [31:0]      cnt_do;

  tnet_cmd_dec #(.BCAST_ID(BCAST)) dut (
    .c_clk_i(c_clk_i), .c_rst_i(c_rst_i), .param_NN(param_NN), .param_ID(param_ID),
    .rx_vld_i(rx_vld_i), .rx_header_i(rx_header_i), .rx_data_i(rx_data_i), .rx_rdy_o(rx_rdy_o),
    .loc_req_o(loc_req_o), .loc_ack_i(loc_ack_i), .loc_op_o(loc_op_o), .loc_ret_o(loc_ret_o),
    .loc_src_o(loc_src_o), .loc_hdt_o(loc_hdt_o), .loc_data_o(loc_data_o),
    .fwd_req_o(fwd_req_o), .fwd_ack_i(fwd_ack_i), .fwd_header_o(fwd_header_o),
    .fwd_data_o(fwd_data_o), .err_o(err_o), .cnt_do(cnt_do)
  );

  always #5 c_clk_i = ~c_clk_i;

  int cyc = 0;
  always @(posedge c_clk_i) cyc <= cyc + 1;

  int n_checks = 0, n_errors = 0;
  int rx_n = 0, loc_n = 0, fwd_n = 0, drop_n = 0;
  exp_t loc_q[$], fwd_q[$];
  int   drop_q[$];

  logic auto_ack = 1'b0, man_loc = 1'b0, man_fwd = 1'b0, rnd_loc = 1'b0, rnd_fwd = 1'b0;
  always @(negedge c_clk_i) begin
    rnd_loc <= ($urandom_range(0, 2) == 0);
    rnd_fwd <= ($urandom_range(0, 2) == 0);
  end
  assign loc_ack_i = auto_ack ? rnd_loc : man_loc;
  assign fwd_ack_i = auto_ack ? rnd_fwd : man_fwd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input logic [1:0] typ, input logic [4:0] op,
      input logic [9:0] dest, input logic [9:0] src, input logic [9:0] step, input logic [23:0] hdt);
    return {typ, op, 3'b101, dest, src, step, hdt};
  endfunction

  // Reference model: packet rules applied directly to header fields.
  function automatic exp_t model(input logic [63:0] h, input logic [63:0] d, input int hs);
    exp_t e;
    logic [9:0] dest = h[53:44], src = h[43:34], step = h[33:24];
    e.drop = (h[63:62] != 2'd0) || (h[61:57] == 5'd0) || (step >= param_NN);
    e.ret  = !e.drop && (src == param_ID);
    e.loc  = !e.drop && (e.ret || dest == param_ID || dest == BCAST);
    e.fwd  = !e.drop && !e.ret && (dest != param_ID);
    e.op   = h[61:57];
    e.src  = src;
    e.hdt  = h[23:0];
    e.data = d;
    e.fhdr = h;
    e.fhdr[33:24] = step + 10'd1;
    e.hs   = hs;
    return e;
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef TNET_DEC_STAT_EN
    return {8'(rx_n), 8'(loc_n), 8'(fwd_n), 8'(drop_n)};
`else
    return 32'd0;
`endif
  endfunction

  // Monitor: pops expectations when a request rises and checks it every cycle it stays high.
  exp_t cur_loc, cur_fwd;
  bit   loc_act = 0, fwd_act = 0;
  always @(negedge c_clk_i) begin
    if (c_rst_i) begin
      loc_act = 0;
      fwd_act = 0;
    end else begin
      if (err_o) begin
        if (drop_q.size() == 0) check("err_unexpected", 1'b1, 1'b0);
        else check("err_cycle", 64'(cyc), 64'(drop_q.pop_front()));
      end
      if (loc_req_o && !loc_act) begin
        if (loc_q.size() == 0) check("loc_req_unexpected", 1'b1, 1'b0);
        else begin
          cur_loc = loc_q.pop_front();
          loc_act = 1;
          check("loc_latency", 64'(cyc), 64'(cur_loc.hs + 1));
        end
      end
      if (loc_req_o && loc_act) begin
        check("loc_op", 64'(loc_op_o), 64'(cur_loc.op));
        check("loc_ret", 64'(loc_ret_o), 64'(cur_loc.ret));
        check("loc_src", 64'(loc_src_o), 64'(cur_loc.src));
        check("loc_hdt", 64'(loc_hdt_o), 64'(cur_loc.hdt));
        check("loc_data", {loc_data_o[1], loc_data_o[0]}, cur_loc.data);
      end
      if (!loc_req_o) loc_act = 0;
      if (fwd_req_o && !fwd_act) begin
        if (fwd_q.size() == 0) check("fwd_req_unexpected", 1'b1, 1'b0);
        else begin
          cur_fwd = fwd_q.pop_front();
          fwd_act = 1;
          check("fwd_latency", 64'(cyc), 64'(cur_fwd.hs + 1));
        end
      end
      if (fwd_req_o && fwd_act) begin
        check("fwd_header", fwd_header_o, cur_fwd.fhdr);
        check("fwd_data", fwd_data_o, cur_fwd.data);
      end
      if (!fwd_req_o) fwd_act = 0;
    end
  end

  // Called at a negedge with rx_rdy_o high; the handshake lands on the next posedge.
  task automatic send(input logic [63:0] h, input logic [63:0] d);
    exp_t e = model(h, d, cyc + 1);
    rx_header_i = h;
    rx_data_i   = d;
    rx_vld_i    = 1'b1;
    rx_n++;
    if (e.drop) begin drop_q.push_back(cyc + 1); drop_n++; end
    if (e.loc) begin loc_q.push_back(e); loc_n++; end
    if (e.fwd) begin fwd_q.push_back(e); fwd_n++; end
    @(negedge c_clk_i);
    rx_vld_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(rx_rdy_o && !loc_req_o && !fwd_req_o && loc_q.size() == 0 &&
             fwd_q.size() == 0 && drop_q.size() == 0) && n < budget) begin
      @(negedge c_clk_i);
      n++;
    end
    check("drain_in_budget", 64'(n < budget), 64'd1);
  endtask

  task automatic ack_both();
    man_loc = 1'b1;
    man_fwd = 1'b1;
    @(negedge c_clk_i);
    man_loc = 1'b0;
    man_fwd = 1'b0;
    wait_idle(20);
  endtask

  function automatic logic [63:0] rand_hdr();
    logic [1:0]  typ  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    logic [4:0]  op   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    logic [9:0]  src  = ($urandom_range(0, 3) == 0) ? param_ID : 10'($urandom);
    logic [9:0]  step = 10'($urandom_range(0, int'(param_NN) + 1));
    logic [9:0]  dest;
    case ($urandom_range(0, 3))
      0:       dest = param_ID;
      1:       dest = BCAST;
      default: dest = 10'($urandom);
    endcase
    return {typ, op, 3'($urandom), dest, src, step, 24'($urandom)};
  endfunction

  task automatic run_random(input int npkt);
    int sent = 0, guard = 0;
    auto_ack = 1'b1;
    while (sent < npkt && guard < 20000) begin
      guard++;
      if (rx_rdy_o && $urandom_range(0, 3) != 0) begin
        send(rand_hdr(), {$urandom, $urandom});
        sent++;
      end else begin
        rx_vld_i    = !rx_rdy_o && ($urandom_range(0, 3) == 0);
        rx_header_i = {$urandom, $urandom};
        @(negedge c_clk_i);
      end
    end
    rx_vld_i = 1'b0;
    check("random_sent", 64'(sent), 64'(npkt));
    wait_idle(200);
    auto_ack = 1'b0;
  endtask

  initial begin
    c_rst_i = 1'b1; rx_vld_i = 1'b0; rx_header_i = '0; rx_data_i = '0;
    param_ID = 10'd3; param_NN = 10'd8;
    repeat (3) @(negedge c_clk_i);
    check("rst_rdy", 64'(rx_rdy_o), 64'd0);
    check("rst_loc_req", 64'(loc_req_o), 64'd0);
    check("rst_fwd_req", 64'(fwd_req_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_fwd_header", fwd_header_o, 64'd0);
    check("rst_cnt", 64'(cnt_do), 64'd0);
    c_rst_i = 1'b0;
    @(negedge c_clk_i);
    check("rdy_after_release", 64'(rx_rdy_o), 64'd1);

    // Own-destination packet: local only.
    send(mk_hdr(2'd0, 5'd5, 10'd3, 10'd1, 10'd2, 24'h00ABCD), 64'h1111_2222_3333_4444);
    @(negedge c_clk_i);
    check("d1_loc_req", 64'(loc_req_o), 64'd1);
    check("d1_fwd_req", 64'(fwd_req_o), 64'd0);
    check("d1_loc_op", 64'(loc_op_o), 64'd5);
    check("d1_loc_src", 64'(loc_src_o), 64'd1);
    ack_both();

    // Foreign destination: forward only, STEP bumped.
    send(mk_hdr(2'd0, 5'd9, 10'd6, 10'd1, 10'd2, 24'h123456), 64'hDEAD_BEEF_0000_0001);
    @(negedge c_clk_i);
    check("d2_fwd_req", 64'(fwd_req_o), 64'd1);
    check("d2_loc_req", 64'(loc_req_o), 64'd0);
    check("d2_fwd_header", fwd_header_o, mk_hdr(2'd0, 5'd9, 10'd6, 10'd1, 10'd3, 24'h123456));
    ack_both();

    // Broadcast with staggered acks, including a forward ack held while its request is low.
    send(mk_hdr(2'd0, 5'd7, BCAST, 10'd0, 10'd2, 24'h000042), 64'h0123_4567_89AB_CDEF);
    @(negedge c_clk_i);
    check("d3_both_loc", 64'(loc_req_o), 64'd1);
    check("d3_both_fwd", 64'(fwd_req_o), 64'd1);
    @(negedge c_clk_i);
    man_fwd = 1'b1;
    @(negedge c_clk_i);
    check("d3_fwd_dropped", 64'(fwd_req_o), 64'd0);
    check("d3_loc_held", 64'(loc_req_o), 64'd1);
    @(negedge c_clk_i);
    @(negedge c_clk_i);
    man_loc = 1'b1;
    check("d3_fwd_ack_ignored", 64'(fwd_req_o), 64'd0);
    check("d3_rdy_busy", 64'(rx_rdy_o), 64'd0);
    @(negedge c_clk_i);
    man_loc = 1'b0;
    man_fwd = 1'b0;
    check("d3_loc_dropped", 64'(loc_req_o), 64'd0);
    check("d3_rdy_back", 64'(rx_rdy_o), 64'd1);

    // Returned packet, then an out-of-range STEP drop.
    send(mk_hdr(2'd0, 5'd3, BCAST, 10'd3, 10'd2, 24'h0), 64'h5);
    @(negedge c_clk_i);
    check("d4_ret", 64'(loc_ret_o), 64'd1);
    check("d4_ret_nofwd", 64'(fwd_req_o), 64'd0);
    ack_both();
    send(mk_hdr(2'd0, 5'd3, 10'd6, 10'd1, 10'd8, 24'h0), 64'h6);
    check("d5_err_pulse", 64'(err_o), 64'd1);
    @(negedge c_clk_i);
    check("d5_err_one_cycle", 64'(err_o), 64'd0);
    check("d5_rdy", 64'(rx_rdy_o), 64'd1);
    check("d5_cnt", 64'(cnt_do), 64'(exp_cnt()));

    run_random(150);
    check("cnt_phase1", 64'(cnt_do), 64'(exp_cnt()));
    param_ID = 10'd517;
    param_NN = 10'd1000;
    run_random(120);
    check("cnt_phase2", 64'(cnt_do), 64'(exp_cnt()));

    // Reset while a local request is outstanding.
    param_ID = 10'd3;
    param_NN = 10'd8;
    send(mk_hdr(2'd0, 5'd4, 10'd3, 10'd1, 10'd0, 24'h7), 64'h8);
    @(negedge c_clk_i);
    check("d6_loc_req", 64'(loc_req_o), 64'd1);
    #2 c_rst_i = 1'b1;
    #1;
    check("d6_async_clear", 64'(loc_req_o), 64'd0);
    check("d6_rdy_in_reset", 64'(rx_rdy_o), 64'd0);
    check("d6_cnt_reset", 64'(cnt_do), 64'd0);
    loc_q.delete(); fwd_q.delete(); drop_q.delete();
    rx_n = 0; loc_n = 0; fwd_n = 0; drop_n = 0;
    man_loc = 1'b0; man_fwd = 1'b0;
    repeat (2) @(negedge c_clk_i);
    c_rst_i = 1'b0;
    @(negedge c_clk_i);
    check("d6_rdy_after", 64'(rx_rdy_o), 64'd1);
    repeat (5) @(negedge c_clk_i);
    check("d6_no_reassert", 64'(loc_req_o | fwd_req_o), 64'd0);
    check("d6_cnt_after", 64'(cnt_do), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
